// File: rtl/dm_pkg.sv
// Debug Module Interface request/response types and encodings shared by DMI agents.
package dm;

    localparam logic [1:0] DTM_NOP   = 2'd0;
    localparam logic [1:0] DTM_READ  = 2'd1;
    localparam logic [1:0] DTM_WRITE = 2'd2;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_ERR     = 2'd2;
    localparam logic [1:0] DTM_BUSY    = 2'd3;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/uart_pkg.sv
// Local FSM state encoding and timeout counter sizing for the DMI target.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dmi_target.sv
// DMI target: accepts one DMI request, performs a register-bus access with
// timeout, and holds the response until the initiator takes it.
module dmi_target
    import dm::*;
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CLEAR_I,
    input  logic        DMI_REQ_VALID_I,
    output logic        DMI_REQ_READY_O,
    input  dmi_req_t    DMI_REQ_I,
    output logic        DMI_RESP_VALID_O,
    input  logic        DMI_RESP_READY_I,
    output dmi_resp_t   DMI_RESP_O,
    output logic        REG_REQ_O,
    output logic        REG_WE_O,
    output logic [6:0]  REG_ADDR_O,
    output logic [31:0] REG_WDATA_O,
    input  logic [31:0] REG_RDATA_I,
    input  logic        REG_ACK_I,
    input  logic        REG_ERR_I
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    // Expiry cycle is the last one before the counter would reach the limit,
    // so exactly TIMEOUT_CYCLES cycles are spent in ACCESS.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    state_e          state_q, state_d;
    dmi_req_t        req_q, req_d;
    dmi_resp_t       resp_q, resp_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            req_q   <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (DMI_REQ_VALID_I) begin
                    req_d = DMI_REQ_I;
                    if (DMI_REQ_I.op == DTM_READ || DMI_REQ_I.op == DTM_WRITE) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d     = RESP;
                        resp_d.data = 32'h0;
                        resp_d.resp = (DMI_REQ_I.op == DTM_NOP) ? DTM_SUCCESS : DTM_ERR;
                    end
                end
            end
            ACCESS: begin
                if (REG_ERR_I) begin
                    state_d     = RESP;
                    resp_d.data = 32'h0;
                    resp_d.resp = DTM_ERR;
                end else if (REG_ACK_I) begin
                    state_d     = RESP;
                    resp_d.data = (req_q.op == DTM_READ) ? REG_RDATA_I : 32'h0;
                    resp_d.resp = DTM_SUCCESS;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    resp_d.data = 32'h0;
                    resp_d.resp = DTM_BUSY;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (DMI_RESP_READY_I) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (CLEAR_I) begin
            state_d = IDLE;
            resp_d  = '0;
        end
    end

    // Ready is masked during clear so an offered request is never silently dropped.
    assign DMI_REQ_READY_O  = (state_q == IDLE) && !RST_I && !CLEAR_I;
    assign DMI_RESP_VALID_O = (state_q == RESP);
    assign DMI_RESP_O       = resp_q;
    assign REG_REQ_O        = (state_q == ACCESS);
    assign REG_WE_O         = (state_q == ACCESS) && (req_q.op == DTM_WRITE);
    assign REG_ADDR_O       = req_q.addr;
    assign REG_WDATA_O      = req_q.data;

endmodule
